// File: rtl/sd_spi_frontend_if.sv
// SD card pin bundle plus command/status outputs of the SPI front end.
`timescale 1ns/1ps
interface sd_spi_frontend_if;
    logic        sd_clk;
    logic        sd_cmd_i;
    logic [3:0]  sd_dat_i;
    logic [3:0]  sd_dat_o;
    logic [3:0]  sd_dat_t;
    logic [47:0] cmd_in;
    logic        cmd_in_act;
    logic [3:0]  card_state;
    logic        mode_spi;
    logic        err_unhandled;

    modport slave (
        input  sd_clk,
        input  sd_cmd_i,
        input  sd_dat_i,
        output sd_dat_o,
        output sd_dat_t,
        output cmd_in,
        output cmd_in_act,
        output card_state,
        output mode_spi,
        output err_unhandled
    );

    modport master (
        output sd_clk,
        output sd_cmd_i,
        output sd_dat_i,
        input  sd_dat_o,
        input  sd_dat_t,
        input  cmd_in,
        input  cmd_in_act,
        input  card_state,
        input  mode_spi,
        input  err_unhandled
    );
endinterface

// File: rtl/sd_spi_frontend.sv
// SPI-mode SD front end: oversampled SCLK/MOSI/CS, 48-bit command
// framing, idle/app-cmd init state and R1/R2/R3/R7 responses on MISO.
`timescale 1ns/1ps
module sd_spi_frontend #(
    parameter logic [23:0] OCR_VOLT  = 24'hFF8000,
    parameter int          NCR_BYTES = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    sd_spi_frontend_if.slave sd
);

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_NCR,
        RSP_SEND
    } rsp_state_e;

    logic [1:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [1:0]  cs_q;
    logic        sclk_d;
    logic        sclk_s;
    logic        mosi_s;
    logic        cs_n;
    logic        rise;
    logic        fall;
    logic [47:0] win;
    logic [47:0] win_nxt;
    logic [2:0]  bit_cnt;
    logic        frame_ok;
    logic [5:0]  idx;
    logic        idle;
    logic        app_cmd;
    logic        mode_spi;
    rsp_state_e  rsp_st;
    logic [39:0] rsp_buf;
    logic [5:0]  rsp_bits;
    logic [7:0]  ncr_cnt;
    logic        miso;
    logic        miso_oe;
    logic [47:0] cmd_in;
    logic        cmd_in_act;
    logic        err_unhandled;

    logic        dec_idle;
    logic        dec_app;
    logic        dec_mode;
    logic        dec_ill;
    logic        dec_rsp;
    logic [2:0]  dec_bytes;
    logic [31:0] dec_tail;
    logic [7:0]  dec_r1;
    logic        unused_dat;

    assign sclk_s   = sclk_q[1];
    assign mosi_s   = mosi_q[1];
    assign cs_n     = cs_q[1];
    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign win_nxt  = {win[46:0], mosi_s};
    assign idx      = win_nxt[45:40];
    assign frame_ok = rise && !cs_n
                   && (win_nxt[47:46] == 2'b01)
                   && win_nxt[0];

    assign unused_dat = &{1'b0, sd.sd_dat_i[2:0]};

    assign sd.sd_dat_o      = {3'b111, miso};
    assign sd.sd_dat_t      = {3'b000, miso_oe};
    assign sd.cmd_in        = cmd_in;
    assign sd.cmd_in_act    = cmd_in_act;
    assign sd.card_state    = idle ? 4'd1 : 4'd2;
    assign sd.mode_spi      = mode_spi;
    assign sd.err_unhandled = err_unhandled;

    // Until CMD0 puts the card in SPI mode every other frame is silently dropped.
    always_comb begin
        dec_idle  = idle;
        dec_app   = 1'b0;
        dec_mode  = mode_spi;
        dec_ill   = 1'b0;
        dec_rsp   = 1'b1;
        dec_bytes = 3'd1;
        dec_tail  = '0;
        unique case (1'b1)
            idx == 6'd0: begin
                dec_idle = 1'b1;
                dec_mode = 1'b1;
            end
            !mode_spi && idx != 6'd0: begin
                dec_app = app_cmd;
                dec_rsp = 1'b0;
            end
            mode_spi && idx == 6'd1: begin
                dec_idle = 1'b0;
            end
            mode_spi && idx == 6'd8: begin
                dec_bytes = 3'd5;
                dec_tail  = {20'h0, win_nxt[19:8]};
            end
            mode_spi && idx == 6'd13: begin
                dec_bytes = 3'd2;
            end
            mode_spi && idx == 6'd41 && app_cmd: begin
                dec_idle = 1'b0;
            end
            mode_spi && idx == 6'd55: begin
                dec_app = 1'b1;
            end
            mode_spi && idx == 6'd58: begin
                dec_bytes = 3'd5;
                dec_tail  = {~idle, 1'b1, 6'b0, OCR_VOLT};
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        dec_r1 = {5'b0, dec_ill, 1'b0, dec_idle};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_q        <= 2'b00;
            mosi_q        <= 2'b11;
            cs_q          <= 2'b11;
            sclk_d        <= 1'b0;
            win           <= '1;
            bit_cnt       <= 3'd0;
            idle          <= 1'b1;
            app_cmd       <= 1'b0;
            mode_spi      <= 1'b0;
            rsp_st        <= RSP_NONE;
            rsp_buf       <= '0;
            rsp_bits      <= 6'd0;
            ncr_cnt       <= 8'd0;
            miso          <= 1'b1;
            miso_oe       <= 1'b0;
            cmd_in        <= '0;
            cmd_in_act    <= 1'b0;
            err_unhandled <= 1'b0;
        end else begin
            sclk_q        <= {sclk_q[0], sd.sd_clk};
            mosi_q        <= {mosi_q[0], sd.sd_cmd_i};
            cs_q          <= {cs_q[0], sd.sd_dat_i[3]};
            sclk_d        <= sclk_s;
            miso_oe       <= ~cs_n;
            cmd_in_act    <= 1'b0;
            err_unhandled <= 1'b0;
            if (cs_n) begin
                bit_cnt <= 3'd0;
                win     <= '1;
                rsp_st  <= RSP_NONE;
                miso    <= 1'b1;
            end else begin
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (frame_ok) begin
                        win           <= '1;
                        cmd_in        <= win_nxt;
                        cmd_in_act    <= 1'b1;
                        idle          <= dec_idle;
                        app_cmd       <= dec_app;
                        mode_spi      <= dec_mode;
                        err_unhandled <= dec_rsp & dec_ill;
                        rsp_buf       <= {dec_r1, dec_tail};
                        rsp_bits      <= {dec_bytes, 3'b000};
                        ncr_cnt       <= 8'(NCR_BYTES);
                        rsp_st        <= dec_rsp ? RSP_NCR : RSP_NONE;
                    end else begin
                        win <= win_nxt;
                        if (rsp_st == RSP_NCR
                            && bit_cnt == 3'd7
                            && ncr_cnt != 8'd0)
                            ncr_cnt <= ncr_cnt - 8'd1;
                    end
                end
                // MISO moves only on falls so the host sees it stable at rise.
                if (fall) begin
                    unique case (rsp_st)
                        RSP_NCR: begin
                            if (ncr_cnt == 8'd0 && bit_cnt == 3'd0) begin
                                miso     <= rsp_buf[39];
                                rsp_buf  <= {rsp_buf[38:0], 1'b0};
                                rsp_bits <= rsp_bits - 6'd1;
                                rsp_st   <= RSP_SEND;
                            end else begin
                                miso <= 1'b1;
                            end
                        end
                        RSP_SEND: begin
                            if (rsp_bits == 6'd0) begin
                                miso   <= 1'b1;
                                rsp_st <= RSP_NONE;
                            end else begin
                                miso     <= rsp_buf[39];
                                rsp_buf  <= {rsp_buf[38:0], 1'b0};
                                rsp_bits <= rsp_bits - 6'd1;
                            end
                        end
                        default: begin
                            miso <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_frontend.sv
// Scoreboard bench for sd_spi_frontend: host-side SPI driver, card
// reference model, and independent MISO-byte and frame monitors.
`timescale 1ns/1ps
module tb_sd_spi_frontend;

    typedef struct {
        logic [47:0] cmd;
        logic        err;
        logic        mode;
        logic [3:0]  cstate;
    } frm_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [7:0] exp_q[$];
    frm_t       frm_q[$];
    logic [7:0] m_rsp[$];
    logic       m_idle;
    logic       m_app;
    logic       m_mode;

    sd_spi_frontend_if sd();

    sd_spi_frontend #(
        .OCR_VOLT (24'hFF8000),
        .NCR_BYTES(1)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .sd     (sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Card behaviour straight from the command table.
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             output logic err);
        logic       ill;
        logic [23:0] ocr;
        ocr = 24'hFF8000;
        err = 1'b0;
        m_rsp.delete();
        if (!m_mode && idx != 6'd0) return;
        ill = 1'b0;
        case (idx)
            6'd0: begin m_idle = 1'b1; m_mode = 1'b1; end
            6'd1: m_idle = 1'b0;
            6'd41: if (m_app) m_idle = 1'b0; else ill = 1'b1;
            6'd8, 6'd13, 6'd55, 6'd58: ;
            default: ill = 1'b1;
        endcase
        m_rsp.push_back((ill ? 8'h04 : 8'h00) | (m_idle ? 8'h01 : 8'h00));
        if (idx == 6'd8) begin
            m_rsp.push_back(8'h00);
            m_rsp.push_back(8'h00);
            m_rsp.push_back({4'h0, arg[11:8]});
            m_rsp.push_back(arg[7:0]);
        end
        if (idx == 6'd58) begin
            m_rsp.push_back(m_idle ? 8'h40 : 8'hC0);
            m_rsp.push_back(ocr[23:16]);
            m_rsp.push_back(ocr[15:8]);
            m_rsp.push_back(ocr[7:0]);
        end
        if (idx == 6'd13) m_rsp.push_back(8'h00);
        m_app = (idx == 6'd55);
        err = ill;
    endtask

    task automatic set_cs(input logic v);
        sd.sd_dat_i = {v, 3'b010};
        #80;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] ex);
        if (!sd.sd_dat_i[3]) exp_q.push_back(ex);
        for (int i = 7; i >= 0; i--) begin
            sd.sd_cmd_i = tx[i];
            #40 sd.sd_clk = 1'b1;
            #40 sd.sd_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [7:0] crc, input logic [7:0] pad,
                            input bit use_pad, input int rd, input int extra);
        frm_t        f;
        logic        e;
        logic [47:0] fr;
        int          n;
        fr = {2'b01, idx, arg, crc[7:1], 1'b1};
        model_cmd(idx, arg, e);
        f.cmd    = fr;
        f.err    = e;
        f.mode   = m_mode;
        f.cstate = m_idle ? 4'd1 : 4'd2;
        frm_q.push_back(f);
        if (use_pad) xfer(pad, 8'hFF);
        for (int i = 0; i < 6; i++) xfer(fr[47-8*i -: 8], 8'hFF);
        xfer(8'hFF, 8'hFF);
        n = m_rsp.size();
        if (rd < n) n = rd;
        for (int i = 0; i < n; i++) xfer(8'hFF, m_rsp[i]);
        for (int i = 0; i < extra; i++) xfer(8'hFF, 8'hFF);
    endtask

    task automatic chk_reset();
        chk("rst_dat_o", 64'(sd.sd_dat_o), 64'hF);
        chk("rst_dat_t", 64'(sd.sd_dat_t), 64'h0);
        chk("rst_cmd_in", 64'(sd.cmd_in), 64'h0);
        chk("rst_act", 64'(sd.cmd_in_act), 64'h0);
        chk("rst_state", 64'(sd.card_state), 64'h1);
        chk("rst_mode", 64'(sd.mode_spi), 64'h0);
        chk("rst_err", 64'(sd.err_unhandled), 64'h0);
    endtask

    // MISO byte monitor: assembles bytes at SCLK rise while CS is low.
    initial begin
        logic [7:0] b;
        int         nb;
        logic [7:0] e;
        nb = 0;
        b  = 8'h00;
        forever begin
            @(posedge sd.sd_clk);
            if (!sd.sd_dat_i[3]) begin
                b  = {b[6:0], sd.sd_dat_o[0]};
                nb = nb + 1;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        chk("miso_unexpected", 64'(b), 64'h1FF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("miso_byte", 64'(b), 64'(e));
                    end
                    chk("pin_idle", 64'({sd.sd_dat_t, sd.sd_dat_o[3:1]}),
                        64'h0F);
                end
            end
        end
    end

    // Frame monitor: compares each accepted frame against the scoreboard.
    initial begin
        frm_t f;
        forever begin
            @(negedge clk);
            if (sd.cmd_in_act) begin
                if (frm_q.size() == 0) begin
                    chk("frame_unexpected", 64'(sd.cmd_in), 64'h0);
                end else begin
                    f = frm_q.pop_front();
                    chk("cmd_in", 64'(sd.cmd_in), 64'(f.cmd));
                    chk("err_pulse", 64'(sd.err_unhandled), 64'(f.err));
                    chk("mode_spi", 64'(sd.mode_spi), 64'(f.mode));
                    chk("card_state", 64'(sd.card_state), 64'(f.cstate));
                end
            end else if (sd.err_unhandled) begin
                chk("err_stray", 64'(sd.err_unhandled), 64'h0);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  tbl [12];
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  c7;
        int          pk;
        tbl = '{6'd0, 6'd1, 6'd8, 6'd13, 6'd41, 6'd55,
                6'd58, 6'd55, 6'd41, 6'd2, 6'd17, 6'd63};
        checks   = 0;
        failures = 0;
        m_idle   = 1'b1;
        m_app    = 1'b0;
        m_mode   = 1'b0;
        rst         = 1'b1;
        sd.sd_clk   = 1'b0;
        sd.sd_cmd_i = 1'b1;
        sd.sd_dat_i = 4'b1010;
        #23;
        chk_reset();
        rst = 1'b0;
        #40;

        for (int i = 0; i < 10; i++) xfer(8'hFF, 8'hFF);
        set_cs(1'b0);
        send_cmd(6'd0, 32'h0, 8'h95, 8'h00, 1'b1, 99, 2);
        set_cs(1'b1);
        set_cs(1'b0);
        send_cmd(6'd0, 32'h0, 8'h95, 8'hFF, 1'b1, 99, 1);
        send_cmd(6'd8, 32'h1AA, 8'h87, 8'hFF, 1'b0, 99, 2);
        send_cmd(6'd58, 32'h0, 8'hFD, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd55, 32'h0, 8'h65, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd41, 32'h40000000, 8'h77, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd58, 32'h0, 8'hFD, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd1, 32'h0, 8'hF9, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd13, 32'h0, 8'h0D, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd2, 32'h0, 8'h4D, 8'hFF, 1'b0, 99, 1);

        // CS dropped mid-response: the rest of the R7 must never appear.
        send_cmd(6'd8, 32'h2A5, 8'h87, 8'hFF, 1'b0, 2, 0);
        set_cs(1'b1);
        set_cs(1'b0);
        for (int i = 0; i < 6; i++) xfer(8'hFF, 8'hFF);

        for (int n = 0; n < 25; n++) begin
            idx = tbl[$urandom_range(0, 11)];
            arg = $urandom;
            c7  = 7'($urandom_range(0, 127));
            pk  = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
                set_cs(1'b1);
                set_cs(1'b0);
            end
            send_cmd(idx, arg, {c7, 1'b1}, (pk == 1) ? 8'h00 : 8'hFF,
                     pk != 0, 99, $urandom_range(0, 2));
        end

        // Reset in the middle of a frame.
        xfer(8'h48, 8'hFF);
        xfer(8'h00, 8'hFF);
        xfer(8'h00, 8'hFF);
        rst = 1'b1;
        #20;
        chk_reset();
        m_idle = 1'b1;
        m_app  = 1'b0;
        m_mode = 1'b0;
        set_cs(1'b1);
        rst = 1'b0;
        #40;
        set_cs(1'b0);
        send_cmd(6'd8, 32'h1AA, 8'h87, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd55, 32'h0, 8'h65, 8'hFF, 1'b0, 99, 1);
        send_cmd(6'd0, 32'h0, 8'h95, 8'h00, 1'b1, 99, 1);
        send_cmd(6'd8, 32'h3C7, 8'h87, 8'hFF, 1'b0, 99, 2);

        set_cs(1'b1);
        #200;
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
        chk("frm_q_drained", 64'(frm_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
